// File: rtl/jtcontra_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtcontra_pkg
// Description : Shared constants, types and helpers for the Contra colour
//               mixer: palette geometry, colour channel width, pipeline
//               latency and the transparent colour code.
// Revision    : 1.0 - initial release
// ============================================================================
package jtcontra_pkg;

    localparam int         PAL_AW      = 8;     // palette entries = 2**PAL_AW
    localparam int         COLW        = 5;     // bits per colour channel
    localparam int         PIPE_LAT    = 3;     // pxl_cen cycles, pixel -> RGB
    localparam logic [3:0] TRANSP_CODE = 4'h0;  // colour code of a see-through pixel

    // Palette word layout is xBGR: blue sits in the top channel, red at the
    // bottom, so a packed struct in this order maps straight onto word[14:0].
    typedef struct packed {
        logic [COLW-1:0] b;
        logic [COLW-1:0] g;
        logic [COLW-1:0] r;
    } rgb_t;

    function automatic logic is_opaque(input logic [3:0] code);
        return code != TRANSP_CODE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_dual_ram.sv
`default_nettype none
// ============================================================================
// Module      : jtframe_dual_ram
// Description : Simple dual-port RAM, one clock. Port 0 writes (and reads
//               when RD0_EN=1), port 1 reads. Both read ports are registered
//               and load only when their read enable is high. Reset clears
//               the read registers only, never the array.
//               A write and a port-1 read of the same word on the same edge
//               return the old word.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               addr0/data0/we0    - write port
//               re0/q0             - optional registered read on port 0
//               addr1/re1/q1       - registered read port
// Revision    : 1.0 - initial release
// ============================================================================
module jtframe_dual_ram #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter bit RD0_EN = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    input  logic          we0,
    input  logic          re0,
    output logic [DW-1:0] q0,
    input  logic [AW-1:0] addr1,
    input  logic          re1,
    output logic [DW-1:0] q1
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] q1_d, q1_q;

    always_ff @(posedge clk) begin
        if (we0) begin
            mem[addr0] <= data0;
        end
    end

    always_comb begin
        q1_d = q1_q;
        if (re1) begin
            q1_d = mem[addr1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_q <= '0;
        end else begin
            q1_q <= q1_d;
        end
    end

    assign q1 = q1_q;

    generate
        if (RD0_EN) begin : g_rd0
            logic [DW-1:0] q0_d, q0_q;

            always_comb begin
                q0_d = q0_q;
                if (re0) begin
                    q0_d = mem[addr0];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    q0_q <= '0;
                end else begin
                    q0_q <= q0_d;
                end
            end

            assign q0 = q0_q;
        end else begin : g_no_rd0
            logic unused_re0;
            assign unused_re0 = re0;
            assign q0         = '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/jtcontra_colmix.sv
`default_nettype none
// ============================================================================
// Module      : jtcontra_colmix
// Description : Colour mixer for two graphics layers. Picks the visible pixel
//               by priority and transparency, looks it up in a 256 x 15-bit
//               xBGR palette and outputs 5-bit RGB with blanking aligned.
//               Pipeline (advances on pxl_cen): S1 index, S2 palette word,
//               S3 RGB. The CPU side of the palette is never stalled.
// Config      : JTCONTRA_PAL_READ_EN - when defined, the CPU can read the
//               palette back through pal_dout; otherwise pal_dout is 8'hFF.
// Ports       : clk, rst             - 48 MHz clock, sync active-high reset
//               pxl_cen, cpu_cen     - pixel / CPU clock enables
//               LHBL, LVBL           - active-low blanking in
//               pal_cs, cpu_rnw,
//               cpu_addr, cpu_dout   - CPU palette access (byte addressed)
//               pal_dout             - CPU palette read data
//               gfx1_pxl, gfx2_pxl   - layer pixels {bank[3:0], code[3:0]}
//               red, green, blue     - colour out
//               LHBL_dly, LVBL_dly   - blanking aligned to colour out
// Revision    : 1.0 - initial release
// ============================================================================
module jtcontra_colmix
    import jtcontra_pkg::*;
#(
    parameter bit GFX1_TOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic            cpu_cen,
    input  logic            LHBL,
    input  logic            LVBL,
    input  logic            pal_cs,
    input  logic            cpu_rnw,
    input  logic [PAL_AW:0] cpu_addr,
    input  logic [7:0]      cpu_dout,
    output logic [7:0]      pal_dout,
    input  logic [7:0]      gfx1_pxl,
    input  logic [7:0]      gfx2_pxl,
    output logic [COLW-1:0] red,
    output logic [COLW-1:0] green,
    output logic [COLW-1:0] blue,
    output logic            LHBL_dly,
    output logic            LVBL_dly
);

`ifdef JTCONTRA_PAL_READ_EN
    localparam bit PAL_RD_EN = 1'b1;
`else
    localparam bit PAL_RD_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // S1: layer selection
    // ------------------------------------------------------------------
    logic [7:0]        w_top, w_bot, w_sel;
    logic [PAL_AW-1:0] idx_d, idx_q;

    always_comb begin
        w_top = GFX1_TOP ? gfx1_pxl : gfx2_pxl;
        w_bot = GFX1_TOP ? gfx2_pxl : gfx1_pxl;
        // Both layers clear: gfx2 still supplies the backdrop colour.
        w_sel = gfx2_pxl;
        if (is_opaque(w_top[3:0])) begin
            w_sel = w_top;
        end else if (is_opaque(w_bot[3:0])) begin
            w_sel = w_bot;
        end
        idx_d = pxl_cen ? w_sel : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Palette RAMs. The port-1 read register is the S2 stage itself, so
    // it only loads on pxl_cen.
    // ------------------------------------------------------------------
    logic       w_cpu_we, w_cpu_re;
    logic [7:0] w_pal_lo, w_pal_hi;
    logic [7:0] w_rd_lo,  w_rd_hi;

    // Reset gates the write so a CPU access during reset leaves the palette intact.
    assign w_cpu_we = pal_cs & ~cpu_rnw & cpu_cen & ~rst;

    jtframe_dual_ram #(
        .DW     (8),
        .AW     (PAL_AW),
        .RD0_EN (PAL_RD_EN)
    ) u_pal_lo (
        .clk   (clk),
        .rst   (rst),
        .addr0 (cpu_addr[PAL_AW:1]),
        .data0 (cpu_dout),
        .we0   (w_cpu_we & ~cpu_addr[0]),
        .re0   (w_cpu_re),
        .q0    (w_rd_lo),
        .addr1 (idx_q),
        .re1   (pxl_cen),
        .q1    (w_pal_lo)
    );

    jtframe_dual_ram #(
        .DW     (8),
        .AW     (PAL_AW),
        .RD0_EN (PAL_RD_EN)
    ) u_pal_hi (
        .clk   (clk),
        .rst   (rst),
        .addr0 (cpu_addr[PAL_AW:1]),
        .data0 (cpu_dout),
        .we0   (w_cpu_we & cpu_addr[0]),
        .re0   (w_cpu_re),
        .q0    (w_rd_hi),
        .addr1 (idx_q),
        .re1   (pxl_cen),
        .q1    (w_pal_hi)
    );

    // ------------------------------------------------------------------
    // CPU read-back
    // ------------------------------------------------------------------
`ifdef JTCONTRA_PAL_READ_EN
    logic rd_sel_d, rd_sel_q;

    assign w_cpu_re = pal_cs & cpu_rnw;

    // Remember which byte the last read asked for; both RAMs read together.
    always_comb begin
        rd_sel_d = rd_sel_q;
        if (w_cpu_re) begin
            rd_sel_d = cpu_addr[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel_q <= 1'b0;
        end else begin
            rd_sel_q <= rd_sel_d;
        end
    end

    assign pal_dout = rd_sel_q ? w_rd_hi : w_rd_lo;
`else
    logic [15:0] w_unused_rd;

    assign w_cpu_re    = 1'b0;
    assign w_unused_rd = {w_rd_hi, w_rd_lo};
    assign pal_dout    = 8'hFF;
`endif

    // ------------------------------------------------------------------
    // S3: blanking delay and RGB register
    // ------------------------------------------------------------------
    logic [PIPE_LAT-1:0] lhbl_sr_d, lhbl_sr_q;
    logic [PIPE_LAT-1:0] lvbl_sr_d, lvbl_sr_q;
    rgb_t                rgb_d, rgb_q;
    logic                w_unused_xbit;
    logic                w_active;

    assign w_unused_xbit = w_pal_hi[7];

    // Tap PIPE_LAT-2 is the blanking that belongs to the word now in S2,
    // so the RGB and the *_dly outputs update on the same edge.
    assign w_active = lhbl_sr_q[PIPE_LAT-2] & lvbl_sr_q[PIPE_LAT-2];

    always_comb begin
        lhbl_sr_d = lhbl_sr_q;
        lvbl_sr_d = lvbl_sr_q;
        rgb_d     = rgb_q;
        if (pxl_cen) begin
            lhbl_sr_d = {lhbl_sr_q[PIPE_LAT-2:0], LHBL};
            lvbl_sr_d = {lvbl_sr_q[PIPE_LAT-2:0], LVBL};
            rgb_d     = w_active ? rgb_t'({w_pal_hi[6:0], w_pal_lo}) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lhbl_sr_q <= '0;
            lvbl_sr_q <= '0;
            rgb_q     <= '0;
        end else begin
            lhbl_sr_q <= lhbl_sr_d;
            lvbl_sr_q <= lvbl_sr_d;
            rgb_q     <= rgb_d;
        end
    end

    assign red      = rgb_q.r;
    assign green    = rgb_q.g;
    assign blue     = rgb_q.b;
    assign LHBL_dly = lhbl_sr_q[PIPE_LAT-1];
    assign LVBL_dly = lvbl_sr_q[PIPE_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_jtcontra_colmix.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtcontra_colmix
// Description : Self-checking bench for jtcontra_colmix. Two instances share
//               all inputs: one with gfx1 on top, one with gfx2 on top. A
//               pixel-queue model predicts every output on every clock, and
//               directed literal checks pin the model to known colours.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtcontra_colmix;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pxl_cen = 1'b0;
    logic       cpu_cen = 1'b1;
    logic       LHBL = 1'b0;
    logic       LVBL = 1'b0;
    logic       pal_cs = 1'b0;
    logic       cpu_rnw = 1'b1;
    logic [8:0] cpu_addr = '0;
    logic [7:0] cpu_dout = '0;
    logic [7:0] gfx1_pxl = '0;
    logic [7:0] gfx2_pxl = '0;

    logic [7:0] pd_a, pd_b;
    logic [4:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic       lhd_a, lvd_a, lhd_b, lvd_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jtcontra_colmix #(.GFX1_TOP(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cpu_cen(cpu_cen),
        .LHBL(LHBL), .LVBL(LVBL), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pd_a),
        .gfx1_pxl(gfx1_pxl), .gfx2_pxl(gfx2_pxl),
        .red(r_a), .green(g_a), .blue(b_a), .LHBL_dly(lhd_a), .LVBL_dly(lvd_a)
    );

    jtcontra_colmix #(.GFX1_TOP(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .cpu_cen(cpu_cen),
        .LHBL(LHBL), .LVBL(LVBL), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pd_b),
        .gfx1_pxl(gfx1_pxl), .gfx2_pxl(gfx2_pxl),
        .red(r_b), .green(g_b), .blue(b_b), .LHBL_dly(lhd_b), .LVBL_dly(lvd_b)
    );

    // pixel clock enable: one clk in four
    logic [1:0] pc = 2'd0;
    initial begin
        forever begin
            @(negedge clk);
            pc      = pc + 2'd1;
            pxl_cen = (pc == 2'd0);
        end
    end

    // ------------------------------------------------------------------
    // Model: a queue of pixels in flight. A pixel's colour is taken from the
    // palette as it stands one pixel period after the pixel arrives, and the
    // pixel is shown once two more pixels have arrived behind it.
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0]  i1;   // index seen with gfx1 on top
        logic [7:0]  i0;   // index seen with gfx2 on top
        logic [15:0] w1;
        logic [15:0] w0;
        logic        lh;
        logic        lv;
    } pix_t;

    pix_t        pq[$];
    logic [15:0] pal [256];
`ifdef JTCONTRA_PAL_READ_EN
    logic [7:0]  exp_pd = 8'h00;
`else
    logic [7:0]  exp_pd = 8'hFF;
`endif
    logic [4:0]  er1 = '0, eg1 = '0, eb1 = '0, er0 = '0, eg0 = '0, eb0 = '0;
    logic        elh = 1'b0, elv = 1'b0;
    bit          started = 1'b0;

    function automatic logic [7:0] pick(input logic [7:0] top, input logic [7:0] bot,
                                        input logic [7:0] backdrop);
        if (top[3:0] != 4'h0) return top;
        if (bot[3:0] != 4'h0) return bot;
        return backdrop;
    endfunction

    always @(posedge clk) begin
        pix_t t;
        pix_t p;
        started = 1'b1;
        if (rst) begin
            pq.delete();
`ifdef JTCONTRA_PAL_READ_EN
            exp_pd = 8'h00;
`endif
        end else begin
`ifdef JTCONTRA_PAL_READ_EN
            if (pal_cs && cpu_rnw)
                exp_pd = cpu_addr[0] ? pal[cpu_addr[8:1]][15:8] : pal[cpu_addr[8:1]][7:0];
`endif
            if (pxl_cen) begin
                if (pq.size() > 0) begin
                    t    = pq[pq.size()-1];
                    t.w1 = pal[t.i1];
                    t.w0 = pal[t.i0];
                    pq[pq.size()-1] = t;
                end
                p.i1 = pick(gfx1_pxl, gfx2_pxl, gfx2_pxl);
                p.i0 = pick(gfx2_pxl, gfx1_pxl, gfx2_pxl);
                p.w1 = '0;
                p.w0 = '0;
                p.lh = LHBL;
                p.lv = LVBL;
                pq.push_back(p);
                if (pq.size() > 3) void'(pq.pop_front());
            end
            if (pal_cs && !cpu_rnw && cpu_cen) begin
                if (cpu_addr[0]) pal[cpu_addr[8:1]][15:8] = cpu_dout;
                else             pal[cpu_addr[8:1]][7:0]  = cpu_dout;
            end
        end
        {er1, eg1, eb1, er0, eg0, eb0} = '0;
        elh = 1'b0;
        elv = 1'b0;
        if (pq.size() == 3) begin
            elh = pq[0].lh;
            elv = pq[0].lv;
            if (pq[0].lh && pq[0].lv) begin
                er1 = pq[0].w1[4:0];  eg1 = pq[0].w1[9:5];  eb1 = pq[0].w1[14:10];
                er0 = pq[0].w0[4:0];  eg0 = pq[0].w0[9:5];  eb0 = pq[0].w0[14:10];
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model_red_g1top",   r_a, er1);
            chk("model_green_g1top", g_a, eg1);
            chk("model_blue_g1top",  b_a, eb1);
            chk("model_red_g2top",   r_b, er0);
            chk("model_green_g2top", g_b, eg0);
            chk("model_blue_g2top",  b_b, eb0);
            chk("model_lhbl_dly",    lhd_a, elh);
            chk("model_lvbl_dly",    lvd_a, elv);
            chk("model_lhbl_dly_b",  lhd_b, elh);
            chk("model_pal_dout",    pd_a, exp_pd);
            chk("model_pal_dout_b",  pd_b, exp_pd);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left on a negedge)
    // ------------------------------------------------------------------
    task automatic cpu_write(input logic [8:0] a, input logic [7:0] d);
        pal_cs   = 1'b1;
        cpu_rnw  = 1'b0;
        cpu_addr = a;
        cpu_dout = d;
        @(negedge clk);
        pal_cs   = 1'b0;
        cpu_rnw  = 1'b1;
    endtask

    task automatic wait_pxl(input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (!pxl_cen && guard < 16);
            if (!pxl_cen) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pxl_cen_timeout: got no pxl_cen, expected one within 16 clk");
            end
            @(negedge clk);
        end
    endtask

    task automatic pix(input logic [7:0] a, input logic [7:0] b);
        gfx1_pxl = a;
        gfx2_pxl = b;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clk);
        // reset state
        chk("rst_red",  r_a, 0);
        chk("rst_lhbl", lhd_a, 0);
`ifdef JTCONTRA_PAL_READ_EN
        chk("rst_pal_dout", pd_a, 8'h00);
`else
        chk("rst_pal_dout", pd_a, 8'hFF);
`endif
        rst = 1'b0;

        // fill the whole palette while blanked
        for (int i = 0; i < 512; i++) cpu_write(9'(i), 8'(i * 37 + 11));
        cpu_write(9'h042, 8'h1F);  cpu_write(9'h043, 8'h00);   // entry 0x21 = 0x001F
        cpu_write(9'h06A, 8'h00);  cpu_write(9'h06B, 8'h7C);   // entry 0x35 = 0x7C00
        cpu_write(9'h060, 8'hE0);  cpu_write(9'h061, 8'h03);   // entry 0x30 = 0x03E0
        cpu_cen = 1'b0;
        cpu_write(9'h042, 8'h05);                               // must be ignored
        cpu_cen = 1'b1;

        // both opaque: priority decides
        LHBL = 1'b1;  LVBL = 1'b1;
        pix(8'h21, 8'h35);
        wait_pxl(3);
        chk("g1top_red",   r_a, 31);
        chk("g1top_green", g_a, 0);
        chk("g1top_blue",  b_a, 0);
        chk("g2top_blue",  b_b, 31);
        chk("g2top_red",   r_b, 0);

        // gfx1 transparent -> gfx2
        pix(8'h20, 8'h35);
        wait_pxl(3);
        chk("g1clear_blue", b_a, 31);
        chk("g1clear_red",  r_a, 0);
        // both transparent -> backdrop from gfx2
        pix(8'h20, 8'h30);
        wait_pxl(3);
        chk("backdrop_green", g_a, 31);
        chk("backdrop_blue",  b_a, 0);
        chk("backdrop_green_b", g_b, 31);
        // gfx2 on top but transparent -> gfx1 shows
        pix(8'h21, 8'h30);
        wait_pxl(3);
        chk("g2clear_red_b", r_b, 31);

        // horizontal blanking for 10 pixels
        pix(8'h21, 8'h35);
        wait_pxl(3);
        LHBL = 1'b0;
        wait_pxl(2);
        chk("hblank_dly_still_high", lhd_a, 1);
        chk("hblank_red_before", r_a, 31);
        wait_pxl(1);
        chk("hblank_dly_low", lhd_a, 0);
        chk("hblank_red_zero", r_a, 0);
        wait_pxl(7);
        LHBL = 1'b1;
        wait_pxl(2);
        LVBL = 1'b0;
        wait_pxl(1);
        chk("hblank_recovered", r_a, 31);
        LVBL = 1'b1;
        wait_pxl(3);

        // rewrite the entry on screen at each phase of pxl_cen
        for (int off = 0; off < 4; off++) begin
            repeat (off) @(negedge clk);
            cpu_write(9'h042, 8'(8'h10 + off));
            wait_pxl(2);
        end
        wait_pxl(3);
        chk("live_write_red", r_a, 8'h13);

`ifdef JTCONTRA_PAL_READ_EN
        pal_cs = 1'b1;  cpu_rnw = 1'b1;  cpu_addr = 9'h06B;
        @(negedge clk);
        pal_cs = 1'b0;
        chk("read_6B", pd_a, 8'h7C);
`endif

        // mid-frame reset with a write attempt riding on it
        rst = 1'b1;
        pal_cs = 1'b1;  cpu_rnw = 1'b0;  cpu_addr = 9'h042;  cpu_dout = 8'h1F;
        @(negedge clk);
        pal_cs = 1'b0;  cpu_rnw = 1'b1;
        chk("midrst_red",  r_a, 0);
        chk("midrst_blue", b_b, 0);
        chk("midrst_lhbl", lhd_a, 0);
        rst = 1'b0;
        wait_pxl(3);
        chk("after_rst_red", r_a, 8'h13);
`ifdef JTCONTRA_PAL_READ_EN
        pal_cs = 1'b1;  cpu_rnw = 1'b1;  cpu_addr = 9'h042;
        @(negedge clk);
        pal_cs = 1'b0;
        chk("read_42_kept", pd_a, 8'h13);
        pal_cs = 1'b1;  cpu_addr = 9'h061;
        @(negedge clk);
        pal_cs = 1'b0;
        chk("read_61_kept", pd_a, 8'h03);
`endif
        wait_pxl(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
